// File: rtl/divider_multicycle_arbiter.sv
// rtl/divider_multicycle_arbiter.sv - round-robin sharing of one multicycle divider among NUM_PORTS requesters
module divider_multicycle_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int DIVIDEND_WIDTH  = 32,
  parameter int DIVISOR_WIDTH   = 32,
  parameter int QUOTIENT_WIDTH  = DIVIDEND_WIDTH,
  parameter int REMAINDER_WIDTH = DIVISOR_WIDTH,
  localparam int ID_WIDTH       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                                  rst,
  input  logic                                  clk,
  input  logic                                  cke,
  input  logic [NUM_PORTS*DIVIDEND_WIDTH-1:0]   s_dividend,
  input  logic [NUM_PORTS*DIVISOR_WIDTH-1:0]    s_divisor,
  input  logic [NUM_PORTS-1:0]                  s_valid,
  output logic [NUM_PORTS-1:0]                  s_ready,
  output logic [NUM_PORTS*QUOTIENT_WIDTH-1:0]   m_quotient,
  output logic [NUM_PORTS*REMAINDER_WIDTH-1:0]  m_remainder,
  output logic [NUM_PORTS-1:0]                  m_valid,
  input  logic [NUM_PORTS-1:0]                  m_ready,
  output logic [DIVIDEND_WIDTH-1:0]             div_s_dividend,
  output logic [DIVISOR_WIDTH-1:0]              div_s_divisor,
  output logic                                  div_s_valid,
  input  logic                                  div_s_ready,
  input  logic [QUOTIENT_WIDTH-1:0]             div_m_quotient,
  input  logic [REMAINDER_WIDTH-1:0]            div_m_remainder,
  input  logic                                  div_m_valid,
  output logic                                  div_m_ready,
  output logic                                  busy,
  output logic [ID_WIDTH-1:0]                   owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                      state;
  state_t                      state_next;
  logic [ID_WIDTH-1:0]         rr_ptr;
  logic [ID_WIDTH-1:0]         rr_next;
  logic [DIVIDEND_WIDTH-1:0]   dividend_reg;
  logic [DIVISOR_WIDTH-1:0]    divisor_reg;
  logic                        grant_found;
  logic [ID_WIDTH-1:0]         grant_idx;
  logic [DIVIDEND_WIDTH-1:0]   sel_dividend;
  logic [DIVISOR_WIDTH-1:0]    sel_divisor;
  logic                        owner_ready;

  // Scan from rr_ptr upward with an explicit wrap so non-power-of-2 port counts work.
  always_comb begin : grant_scan
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (!grant_found && (j == idx) && s_valid[j]) begin
          grant_found = 1'b1;
          grant_idx   = ID_WIDTH'(j);
        end
      end
    end
  end

  assign rr_next = (grant_idx == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    owner_ready  = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (grant_idx == ID_WIDTH'(k)) begin
        sel_dividend = s_dividend[k*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
        sel_divisor  = s_divisor[k*DIVISOR_WIDTH +: DIVISOR_WIDTH];
      end
      if (owner == ID_WIDTH'(k)) owner_ready = m_ready[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
    end else if (cke) begin
      state <= state_next;
      if (state == IDLE && grant_found) begin
        dividend_reg <= sel_dividend;
        divisor_reg  <= sel_divisor;
        owner        <= grant_idx;
        rr_ptr       <= rr_next;
      end
    end
  end

  // Outputs are forced low while rst is high so nothing leaks before the reset edge.
  always_comb begin
    state_next  = state;
    s_ready     = '0;
    m_valid     = '0;
    div_s_valid = 1'b0;
    div_m_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (cke && grant_found) begin
            state_next = ISSUE;
            for (int k = 0; k < NUM_PORTS; k++) s_ready[k] = (grant_idx == ID_WIDTH'(k));
          end
        end
        ISSUE: begin
          div_s_valid = 1'b1;
          if (div_s_ready) state_next = WAIT;
        end
        WAIT: begin
          for (int k = 0; k < NUM_PORTS; k++) m_valid[k] = div_m_valid && (owner == ID_WIDTH'(k));
          div_m_ready = owner_ready;
          if (div_m_valid && owner_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign busy           = !rst && (state != IDLE);
  assign div_s_dividend = dividend_reg;
  assign div_s_divisor  = divisor_reg;
  assign m_quotient     = {NUM_PORTS{div_m_quotient}};
  assign m_remainder    = {NUM_PORTS{div_m_remainder}};

endmodule

// File: tb/tb_divider_multicycle_arbiter.sv
// tb/tb_divider_multicycle_arbiter.sv - directed scoreboard bench for divider_multicycle_arbiter
module tb_divider_multicycle_arbiter;
  localparam int NP   = 4;
  localparam int W    = 32;
  localparam int DLAT = 5;

  logic            rst, clk, cke;
  logic [NP*W-1:0] s_dividend, s_divisor, m_quotient, m_remainder;
  logic [NP-1:0]   s_valid, s_ready, m_valid, m_ready;
  logic [W-1:0]    div_s_dividend, div_s_divisor, div_m_quotient, div_m_remainder;
  logic            div_s_valid, div_s_ready, div_m_valid, div_m_ready, busy;
  logic [1:0]      owner;

  divider_multicycle_arbiter dut (
    .rst(rst), .clk(clk), .cke(cke),
    .s_dividend(s_dividend), .s_divisor(s_divisor), .s_valid(s_valid), .s_ready(s_ready),
    .m_quotient(m_quotient), .m_remainder(m_remainder), .m_valid(m_valid), .m_ready(m_ready),
    .div_s_dividend(div_s_dividend), .div_s_divisor(div_s_divisor),
    .div_s_valid(div_s_valid), .div_s_ready(div_s_ready),
    .div_m_quotient(div_m_quotient), .div_m_remainder(div_m_remainder),
    .div_m_valid(div_m_valid), .div_m_ready(div_m_ready),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural multicycle divider sharing clk/rst/cke with the arbiter.
  logic         d_busy, d_done;
  logic [2:0]   d_cnt;
  logic [W-1:0] d_a, d_b, d_q, d_r;
  assign div_s_ready     = !d_busy && !d_done;
  assign div_m_valid     = d_done;
  assign div_m_quotient  = d_q;
  assign div_m_remainder = d_r;
  always @(posedge clk) begin
    if (rst) begin
      d_busy <= 1'b0; d_done <= 1'b0; d_cnt <= '0; d_q <= '0; d_r <= '0; d_a <= '0; d_b <= '0;
    end else if (cke) begin
      if (div_s_valid && div_s_ready) begin
        d_a <= div_s_dividend; d_b <= div_s_divisor; d_busy <= 1'b1; d_cnt <= 3'(DLAT);
      end else if (d_busy) begin
        if (d_cnt == 3'd1) begin
          d_busy <= 1'b0; d_done <= 1'b1;
          d_q <= (d_b == 0) ? '1 : d_a / d_b;
          d_r <= (d_b == 0) ? d_a : d_a % d_b;
        end else d_cnt <= d_cnt - 3'd1;
      end else if (d_done && div_m_ready) d_done <= 1'b0;
    end
  end

  int checks = 0, errors = 0, cyc = 0, deliv = 0, gcyc = 0, dcyc = 0, last_port = 0;
  logic [W-1:0] ra[NP][8], rb[NP][8], eq[NP][8], er[NP][8], lq[NP], lr[NP], last_q, last_r;
  int rh[NP], rt[NP], eh[NP], et[NP];
  bit hs[NP];
  int glog[$];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NP; i++) begin
      s_valid[i] = (rh[i] != rt[i]);
      s_dividend[i*W +: W] = s_valid[i] ? ra[i][rh[i]%8] : '0;
      s_divisor[i*W +: W]  = s_valid[i] ? rb[i][rh[i]%8] : '0;
    end
  endtask

  task automatic push_req(int p, logic [W-1:0] a, logic [W-1:0] b);
    ra[p][rt[p]%8] = a; rb[p][rt[p]%8] = b; rt[p]++;
    apply();
  endtask

  task automatic sample();
    logic [W-1:0] a, b;
    cyc++;
    if (rst) check("rst_outputs_low", {s_ready, m_valid, div_s_valid, div_m_ready, busy}, 0);
    else begin
      if (!cke) check("cke_low_s_ready", s_ready, 0);
      check("s_ready_onehot0", $onehot0(s_ready), 1);
      check("m_valid_onehot0", $onehot0(m_valid), 1);
      if (cke) for (int i = 0; i < NP; i++) begin
        if (s_valid[i] && s_ready[i]) begin
          a = s_dividend[i*W +: W]; b = s_divisor[i*W +: W];
          eq[i][et[i]%8] = (b == 0) ? '1 : a / b;
          er[i][et[i]%8] = (b == 0) ? a : a % b;
          et[i]++; hs[i] = 1'b1; glog.push_back(i); gcyc = cyc;
        end
        if (m_valid[i] && m_ready[i]) begin
          check("result_expected_for_port", (et[i] != eh[i]), 1);
          if (et[i] != eh[i]) begin
            check("sb_quotient", m_quotient[i*W +: W], eq[i][eh[i]%8]);
            check("sb_remainder", m_remainder[i*W +: W], er[i][eh[i]%8]);
            eh[i]++;
          end
          lq[i] = m_quotient[i*W +: W]; lr[i] = m_remainder[i*W +: W];
          last_q = lq[i]; last_r = lr[i]; last_port = i; deliv++; dcyc = cyc;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) if (hs[i]) begin rh[i]++; hs[i] = 1'b0; end
    apply();
  endtask

  task automatic wait_deliv(int n, int limit, string tag);
    int k = 0;
    while (deliv < n && k < limit) begin step(); k++; end
    check({tag, "_deliver_timeout"}, (deliv >= n), 1);
  endtask

  task automatic wait_grants(int n, int limit, string tag);
    int k = 0;
    while (glog.size() < n && k < limit) begin step(); k++; end
    check({tag, "_grant_timeout"}, (glog.size() >= n), 1);
  endtask

  initial begin
    int base, rc, l0, k;
    int ord2[6] = '{0, 1, 2, 3, 0, 1};
    int ord6[4] = '{0, 1, 0, 0};
    logic [W-1:0] t2q[4] = '{3, 3, 4, 4};
    logic [W-1:0] t2r[4] = '{1, 2, 0, 1};
    rst = 1'b1; cke = 1'b1; m_ready = '1; s_valid = '0; s_dividend = '0; s_divisor = '0;
    for (int i = 0; i < NP; i++) begin rh[i] = 0; rt[i] = 0; eh[i] = 0; et[i] = 0; hs[i] = 1'b0; end
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_busy", busy, 0);
    check("reset_owner", owner, 0);
    check("reset_div_s_valid", div_s_valid, 0);

    // 1: single request on port 2
    glog.delete(); base = deliv;
    push_req(2, 100, 7);
    wait_deliv(base + 1, 60, "t1");
    check("t1_port", last_port, 2);
    check("t1_quotient", last_q, 14);
    check("t1_remainder", last_r, 2);
    check("t1_grant_count", glog.size(), 1);
    check("t1_latency", dcyc - gcyc, DLAT + 2);
    step();
    check("t1_busy_idle", busy, 0);
    check("t1_owner", owner, 2);

    // 2: all ports hold valid from reset
    rst = 1'b1;
    for (int i = 0; i < NP; i++) begin push_req(i, i + 10, 3); push_req(i, i + 10, 3); end
    step(); step();
    rst = 1'b0; glog.delete(); base = deliv;
    wait_deliv(base + 8, 200, "t2");
    for (int i = 0; i < 6; i++) check("t2_grant_order", glog[i], ord2[i]);
    for (int i = 0; i < NP; i++) begin
      check("t2_quotient", lq[i], t2q[i]);
      check("t2_remainder", lr[i], t2r[i]);
    end

    // 3: result backpressure on port 1 blocks port 3
    glog.delete(); base = deliv;
    m_ready[1] = 1'b0;
    push_req(1, 5, 9); push_req(3, 40, 6);
    k = 0;
    while (!m_valid[1] && k < 40) begin step(); k++; end
    check("t3_m_valid_timeout", m_valid[1], 1);
    for (int i = 0; i < 20; i++) begin
      step();
      check("t3_hold_flags", {m_valid, s_ready[3]}, {4'b0010, 1'b0});
      check("t3_hold_result", {m_quotient[W +: W], m_remainder[W +: W]}, {32'd0, 32'd5});
    end
    m_ready[1] = 1'b1;
    wait_deliv(base + 1, 5, "t3a");
    rc = dcyc;
    wait_grants(2, 5, "t3");
    check("t3_port3_next_cycle", gcyc - rc, 1);
    wait_deliv(base + 2, 40, "t3b");
    check("t3_order0", glog[0], 1);
    check("t3_order1", glog[1], 3);
    check("t3_port3_q", lq[3], 6);
    check("t3_port3_r", lr[3], 4);

    // 4: cke low for 10 cycles during WAIT
    glog.delete(); base = deliv;
    push_req(0, 200, 9);
    wait_deliv(base + 1, 40, "t4a");
    l0 = dcyc - gcyc;
    check("t4_base_latency", l0, DLAT + 2);
    push_req(0, 200, 9);
    wait_grants(2, 10, "t4");
    repeat (3) step();
    cke = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t4_frozen", {busy, owner, m_valid, div_m_valid}, {1'b1, 2'd0, 4'b0, 1'b0});
    end
    cke = 1'b1;
    wait_deliv(base + 2, 40, "t4b");
    check("t4_latency_plus10", dcyc - gcyc, l0 + 10);
    check("t4_quotient", last_q, 22);
    check("t4_remainder", last_r, 2);

    // 5: reset during WAIT aborts port 0
    glog.delete();
    push_req(0, 77, 4);
    wait_grants(1, 10, "t5");
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_m_valid", m_valid, 0);
    check("t5_pending_port0", et[0] - eh[0], 1);
    eh[0] = et[0];
    glog.delete(); base = deliv;
    push_req(0, 50, 7); push_req(3, 91, 10);
    wait_deliv(base + 2, 60, "t5");
    check("t5_rr_reset_order0", glog[0], 0);
    check("t5_rr_reset_order1", glog[1], 3);
    check("t5_port3_q", lq[3], 9);
    check("t5_port3_r", lr[3], 1);
    check("t5_port0_q", lq[0], 7);

    // 6: continuous port 0 does not starve port 1
    glog.delete(); base = deliv;
    push_req(0, 10, 2); push_req(0, 11, 2); push_req(0, 12, 2);
    wait_grants(1, 10, "t6");
    push_req(1, 33, 5);
    wait_deliv(base + 4, 150, "t6");
    for (int i = 0; i < 4; i++) check("t6_grant_order", glog[i], ord6[i]);
    check("t6_port1_q", lq[1], 6);
    check("t6_port1_r", lr[1], 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/divider_multicycle_arbiter.md
Name: divider_multicycle_arbiter

Overview:
- Shares one unsigned multicycle divider between NUM_PORTS requesters, each with its own valid/ready operand and result channels.
- Round-robin arbitration; one division is outstanding at a time. The result is returned only to the requester that issued the operands.
- The block sits between several datapath clients and a single divider instance. The divider takes operands on valid/ready, has one operation in flight, and registers its result on valid/ready.
- The divider must be driven by the same clk, rst and cke as this block.

Parameters:
NUM_PORTS, 4, number of requesters; must be 1 or more.
DIVIDEND_WIDTH, 32, dividend width.
DIVISOR_WIDTH, 32, divisor width.
QUOTIENT_WIDTH, DIVIDEND_WIDTH, quotient width.
REMAINDER_WIDTH, DIVISOR_WIDTH, remainder width.
ID_WIDTH, max(clog2(NUM_PORTS),1), width of the owner index (derived, localparam).

Ports:
rst  in  1  synchronous reset, active-high
clk  in  1  clock
cke  in  1  clock enable; all state holds while low
s_dividend  in  NUM_PORTS*DIVIDEND_WIDTH  per-port dividend, port i at slice [i*DIVIDEND_WIDTH +: DIVIDEND_WIDTH]
s_divisor  in  NUM_PORTS*DIVISOR_WIDTH  per-port divisor
s_valid  in  NUM_PORTS  per-port request valid
s_ready  out  NUM_PORTS  per-port accept; one-hot or zero
m_quotient  out  NUM_PORTS*QUOTIENT_WIDTH  per-port quotient; every slice carries the divider quotient
m_remainder  out  NUM_PORTS*REMAINDER_WIDTH  per-port remainder; every slice carries the divider remainder
m_valid  out  NUM_PORTS  per-port result valid; one-hot or zero
m_ready  in  NUM_PORTS  per-port result ready
div_s_dividend  out  DIVIDEND_WIDTH  operand to divider
div_s_divisor  out  DIVISOR_WIDTH  operand to divider
div_s_valid  out  1  operand valid to divider
div_s_ready  in  1  divider operand ready
div_m_quotient  in  QUOTIENT_WIDTH  divider quotient
div_m_remainder  in  REMAINDER_WIDTH  divider remainder
div_m_valid  in  1  divider result valid
div_m_ready  out  1  result ready to divider
busy  out  1  high in any state other than IDLE
owner  out  ID_WIDTH  index of the current or last granted port

Behaviour:
- Reset (synchronous, active-high, on rst): state=IDLE, rr_ptr=0, owner=0, operand registers=0.
  - All outputs are 0 during and after reset: s_ready, m_valid, div_s_valid, div_m_ready, busy.
  - Reset in any state aborts the operation with no result delivered. The divider is reset by the same rst.
- All transitions occur only on clk edges with cke=1. When cke=0, every register holds and s_ready=0.
- IDLE:
  - Grant g = first index i with s_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_PORTS.
  - When a grant exists and cke=1, s_ready[g]=1 combinationally; all other s_ready bits are 0.
  - On that edge: capture s_dividend[g] and s_divisor[g], set owner<=g, set rr_ptr<=(g+1) mod NUM_PORTS (explicit wrap, NUM_PORTS need not be a power of 2), go to ISSUE.
  - With no s_valid bit set: stay in IDLE, rr_ptr unchanged.
- ISSUE:
  - div_s_valid=1 and div_s_dividend/div_s_divisor come from the registers.
  - On div_s_valid && div_s_ready: go to WAIT.
  - The operands stay stable while div_s_ready=0.
- WAIT:
  - m_valid[owner]=div_m_valid; all other m_valid bits are 0.
  - div_m_ready=m_ready[owner]; the quotient and remainder pass through combinationally.
  - On div_m_valid && m_ready[owner]: go to IDLE.
  - Backpressure from m_ready[owner]=0 holds the result and blocks new grants.
- s_ready is 0 in ISSUE and WAIT, so requests arriving there wait.
- Latency, s_valid to m_valid: 1 cycle (IDLE to ISSUE) + divider accept + divider compute latency. No extra register on the result path.
- Throughput: one division per divider latency + 2 cycles.
- Fairness: a port with s_valid held high is granted within NUM_PORTS grants.
- No arithmetic is performed; widths pass through unchanged. Divide-by-zero results are whatever the divider returns.
- With NUM_PORTS=1: owner is always 0 and the arbiter degenerates to a pass-through sequencer.

Test Plan:
1. NUM_PORTS=4; port 2 alone sends 100/7 -> s_ready[2] pulses once; m_valid[2] rises with quotient 14, remainder 2; m_valid[0,1,3]=0; busy returns to 0.
2. All four ports hold s_valid from reset with operands (i+10)/3 -> grant order 0,1,2,3,0,1. Each port gets quotient (i+10)/3 (3,3,4,4), remainder 1,2,0,1.
3. Port 1 sends 5/9 with m_ready[1]=0 for 20 cycles while port 3 is valid -> m_valid[1] held with quotient 0, remainder 5; s_ready[3] stays 0 until the m_ready[1] handshake, then port 3 is granted next cycle.
4. cke=0 for 10 cycles in the middle of WAIT -> state, owner and outputs frozen; after cke returns the result is correct and total latency grows by exactly 10 cycles.
5. rst asserted during WAIT for port 0 -> next cycle busy=0, m_valid=0, rr_ptr=0; port 0's outstanding result is never delivered; a new port 3 request gets a correct result.
6. Port 0 holds s_valid continuously and port 1 requests once -> port 1 is granted immediately after port 0's current operation completes, not starved.
